ps2_key_decoder: RTL and testbench

Parametrised PS/2 keyboard receiver and key-state tracker. It replaces the free-running bit counter and the fixed two-key compare with a filtered, framed receiver that checks start, parity and stop bits, recovers from timeouts, and decodes E0/F0 prefixes. It emits one strobe per make or break event and keeps a held-level bitmap of NUM_KEYS configurable keys. It sits between the board's PS2_KBCLK/PS2_KBDAT pins and the character control logic, clocked by CLOCK_50.

---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_rx_frame.sv | 150 +++++++++++++++
 rtl/ps2_key_decoder.sv | 119 +++++++++++
 tb/tb_ps2_key_decoder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Imported by the frame receiver and the key decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_BAT = 8'hAA;

    localparam int KEY_W = 9;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizers, clock glitch filter, 11-bit frame
// FSM with odd-parity and stop checks, and an inter-edge timeout.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_s1_q, clk_s2_q;
    logic          dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic          filt_prev_q;
    logic [FW-1:0] fcnt_q, fcnt_d;

    frame_state_e  state_q, state_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic fall;
    logic tmo_hit;
    logic fall_eff;
    logic valid_d;
    logic err_d;

    always_comb begin
        fcnt_d = '0;
        filt_d = filt_q;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = ~filt_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    assign fall     = filt_prev_q & ~filt_q;
    assign tmo_hit  = (state_q != ST_IDLE) &&
                      (tmo_q == TW'(TIMEOUT_CYCLES));
    // An expiring timeout swallows a coincident falling edge.
    assign fall_eff = fall & ~tmo_hit;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        par_d   = par_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (fall_eff) begin
                    if (!dat_s2_q) begin
                        state_d = ST_DATA;
                        bcnt_d  = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (fall_eff) begin
                    sh_d   = {dat_s2_q, sh_q[7:1]};
                    bcnt_d = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall_eff) begin
                    par_d   = (^sh_q) ^ dat_s2_q;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_eff) begin
                    if (par_q && dat_s2_q) begin
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tmo_hit) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end

        if (state_q == ST_IDLE || fall || tmo_hit) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= ST_IDLE;
            bcnt_q      <= '0;
            sh_q        <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
        end else begin
            clk_s1_q    <= ps2_clk_i;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= ps2_dat_i;
            dat_s2_q    <= dat_s1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            sh_q        <= sh_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
        end
    end

    assign byte_o       = sh_q;
    assign byte_valid_o = valid_d;
    assign frame_err_o  = err_d;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: E0/F0 prefix handling, make/break strobes and a
// held-level bitmap of configurable keys.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int                          NUM_KEYS       = 2,
    // Slot 0 (LSBs) = 0_16, slot 1 = 0_1E.
    parameter logic [NUM_KEYS*KEY_W-1:0]   KEY_CODES      = {9'h0_1E, 9'h0_16},
    parameter int                          FILTER_LEN     = 8,
    parameter int                          TIMEOUT_CYCLES = 50000
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                PS2_CLK,
    input  logic                PS2_DAT,
    output logic [7:0]          ScanCode,
    output logic                Extended,
    output logic                Break,
    output logic                CodeValid,
    output logic                FrameError,
    output logic [NUM_KEYS-1:0] KeyDown
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    ps2_rx_frame #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk_i       (Clock),
        .rst_ni      (Resetn),
        .ps2_clk_i   (PS2_CLK),
        .ps2_dat_i   (PS2_DAT),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .frame_err_o (rx_err)
    );

    logic [7:0]          scan_q, scan_d;
    logic                ext_q, ext_d;
    logic                brk_q, brk_d;
    logic                cv_q, cv_d;
    logic                fe_q, fe_d;
    logic                ep_q, ep_d;
    logic                bp_q, bp_d;
    logic [NUM_KEYS-1:0] kd_q, kd_d;

    always_comb begin
        scan_d = scan_q;
        ext_d  = ext_q;
        brk_d  = brk_q;
        cv_d   = 1'b0;
        fe_d   = 1'b0;
        ep_d   = ep_q;
        bp_d   = bp_q;
        kd_d   = kd_q;

        if (rx_err) begin
            fe_d = 1'b1;
            ep_d = 1'b0;
            bp_d = 1'b0;
        end else if (rx_valid) begin
            case (rx_byte)
                PS2_EXT: ep_d = 1'b1;
                PS2_BRK: bp_d = 1'b1;
                PS2_BAT: begin
                    kd_d = '0;
                    ep_d = 1'b0;
                    bp_d = 1'b0;
                end
                default: begin
                    cv_d   = 1'b1;
                    scan_d = rx_byte;
                    ext_d  = ep_q;
                    brk_d  = bp_q;
                    ep_d   = 1'b0;
                    bp_d   = 1'b0;
                    for (int i = 0; i < NUM_KEYS; i++) begin
                        if (KEY_CODES[i*KEY_W +: KEY_W] == {ep_q, rx_byte}) begin
                            kd_d[i] = ~bp_q;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            scan_q <= '0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            cv_q   <= 1'b0;
            fe_q   <= 1'b0;
            ep_q   <= 1'b0;
            bp_q   <= 1'b0;
            kd_q   <= '0;
        end else begin
            scan_q <= scan_d;
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            cv_q   <= cv_d;
            fe_q   <= fe_d;
            ep_q   <= ep_d;
            bp_q   <= bp_d;
            kd_q   <= kd_d;
        end
    end

    assign ScanCode   = scan_q;
    assign Extended   = ext_q;
    assign Break      = brk_q;
    assign CodeValid  = cv_q;
    assign FrameError = fe_q;
    assign KeyDown    = kd_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: two instances (default keys and an E0 74 slot)
// share one PS/2 stream; decoded events are scored against a queue.
module tb_ps2_key_decoder;

    localparam int TMO  = 400;
    localparam int HALF = 40;

    typedef struct packed {
        logic [7:0] scan;
        logic       ext;
        logic       brk;
        logic [1:0] kd0;
        logic [1:0] kd1;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic ps2c = 1'b1;
    logic ps2d = 1'b1;

    logic [7:0] sc0, sc1;
    logic       ex0, ex1, br0, br1, cv0, cv1, fe0, fe1;
    logic [1:0] kd0, kd1;

    int   errors = 0;
    int   checks = 0;
    int   fe_cnt = 0;
    int   cv_cnt = 0;
    int   n_push = 0;
    int   fe_ref;
    int   cv_ref;
    exp_t sb[$];

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES(TMO)
    ) dut0 (
        .Clock(clk), .Resetn(resetn), .PS2_CLK(ps2c), .PS2_DAT(ps2d),
        .ScanCode(sc0), .Extended(ex0), .Break(br0),
        .CodeValid(cv0), .FrameError(fe0), .KeyDown(kd0)
    );

    ps2_key_decoder #(
        .KEY_CODES     ({9'h1_74, 9'h0_16}),
        .TIMEOUT_CYCLES(TMO)
    ) dut1 (
        .Clock(clk), .Resetn(resetn), .PS2_CLK(ps2c), .PS2_DAT(ps2d),
        .ScanCode(sc1), .Extended(ex1), .Break(br1),
        .CodeValid(cv1), .FrameError(fe1), .KeyDown(kd1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wcyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2d = b;
        wcyc(HALF);
        ps2c = 1'b0;
        wcyc(HALF);
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(1'b1);
        wcyc(HALF);
    endtask

    task automatic expect_ev(input logic [7:0] s, input logic e,
                             input logic k, input logic [1:0] a,
                             input logic [1:0] c);
        exp_t x;
        x.scan = s;
        x.ext  = e;
        x.brk  = k;
        x.kd0  = a;
        x.kd1  = c;
        sb.push_back(x);
        n_push++;
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        check({tag, "_sc0"}, sc0, 0);
        check({tag, "_sc1"}, sc1, 0);
        check({tag, "_flags0"}, {ex0, br0, cv0, fe0}, 0);
        check({tag, "_flags1"}, {ex1, br1, cv1, fe1}, 0);
        check({tag, "_kd0"}, kd0, 0);
        check({tag, "_kd1"}, kd1, 0);
    endtask

    always @(negedge clk) begin
        if (fe0) fe_cnt++;
        if (cv0) cv_cnt++;
        if (cv0 || cv1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_cv: got sc=%0h expected none", sc0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("cv0", cv0, 1);
                check("cv1", cv1, 1);
                check("scan0", sc0, e.scan);
                check("scan1", sc1, e.scan);
                check("ext", {ex0, ex1}, {e.ext, e.ext});
                check("brk", {br0, br1}, {e.brk, e.brk});
                check("kd0", kd0, e.kd0);
                check("kd1", kd1, e.kd1);
            end
        end
    end

    initial begin
        wcyc(5);
        check_zero("reset");
        resetn = 1'b1;
        wcyc(20);

        expect_ev(8'h16, 1'b0, 1'b0, 2'b01, 2'b01);
        send_frame(8'h16, 1'b0);
        send_frame(8'hF0, 1'b0);
        expect_ev(8'h16, 1'b0, 1'b1, 2'b00, 2'b00);
        send_frame(8'h16, 1'b0);

        send_frame(8'hE0, 1'b0);
        expect_ev(8'h74, 1'b1, 1'b0, 2'b00, 2'b10);
        send_frame(8'h74, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        expect_ev(8'h74, 1'b1, 1'b1, 2'b00, 2'b00);
        send_frame(8'h74, 1'b0);

        expect_ev(8'h16, 1'b0, 1'b0, 2'b01, 2'b01);
        send_frame(8'h16, 1'b0);
        fe_ref = fe_cnt;
        cv_ref = cv_cnt;
        send_frame(8'h1E, 1'b1);
        check("par_fe", fe_cnt - fe_ref, 1);
        check("par_cv", cv_cnt - cv_ref, 0);
        check("par_kd0", kd0, 2'b01);

        fe_ref = fe_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        wcyc(TMO + 10);
        check("tmo_fe", fe_cnt - fe_ref, 1);
        expect_ev(8'h1E, 1'b0, 1'b0, 2'b11, 2'b01);
        send_frame(8'h1E, 1'b0);

        fe_ref = fe_cnt;
        cv_ref = cv_cnt;
        ps2d = 1'b0;
        wcyc(HALF);
        ps2c = 1'b0;
        wcyc(4);
        ps2c = 1'b1;
        wcyc(HALF);
        ps2d = 1'b1;
        wcyc(HALF);
        send_frame(8'hAA, 1'b0);
        check("bat_fe", fe_cnt - fe_ref, 0);
        check("bat_cv", cv_cnt - cv_ref, 0);
        check("bat_kd", {kd0, kd1}, 4'b0000);

        send_frame(8'hF0, 1'b0);
        send_frame(8'hAA, 1'b0);
        expect_ev(8'h1E, 1'b0, 1'b0, 2'b10, 2'b00);
        send_frame(8'h1E, 1'b0);

        fe_ref = fe_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        resetn = 1'b0;
        wcyc(3);
        check_zero("midrst");
        resetn = 1'b1;
        wcyc(TMO + 50);
        check("midrst_fe", fe_cnt - fe_ref, 0);
        check("midrst_sc", sc0, 0);
        expect_ev(8'h16, 1'b0, 1'b0, 2'b01, 2'b01);
        send_frame(8'h16, 1'b0);

        wcyc(50);
        check("sb_drain", sb.size(), 0);
        check("cv_total", cv_cnt, n_push);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
